pll_clkgen_multi: RTL and testbench

Parametrised multi-channel digital clock generator that runs from one reference clock, the successor to the single-output fixed PLL wrapper. It produces NUM_CH divided square-wave outputs with per-channel period, high time and phase offset. Each output has a matching start-of-period enable pulse. A lock FSM asserts `locked` only after all channels have been realigned and have settled. It sits beside the CPU clock PLL and supplies slow peripheral clocks and clock enables; channels can be reconfigured at runtime through a valid/ready port.

---
 rtl/pll_clkgen_multi.sv | 201 ++++++++++++++++++++
 tb/tb_pll_clkgen_multi.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_clkgen_multi.sv
// pll_clkgen_multi
// Multi-channel divided clock generator running entirely on refclk.
// Each channel produces a registered square wave (outclk) and a
// start-of-period pulse (outclk_en) from a free-running period counter.
// A lock FSM (ALIGN -> SETTLE -> LOCKED) realigns every channel together
// and raises `locked` once the settle window has elapsed.
//
// Build option: define PLL_CLKGEN_RECFG_EN to enable the runtime
// valid/ready reconfiguration port. When it is undefined, cfg_ready is
// tied low, cfg_* inputs are ignored and every channel keeps its
// DIV_INIT / HIGH_INIT / phase 0 settings.
module pll_clkgen_multi #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int LOCK_CYCLES = 16,
    parameter int DIV_INIT    = 4,
    parameter int HIGH_INIT   = 2,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_high,
    input  logic [DIV_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] outclk,
    output logic [NUM_CH-1:0] outclk_en,
    output logic              locked
);

    // Settle counter only needs to reach LOCK_CYCLES-1.
    localparam int SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ALIGN,
        ST_SETTLE,
        ST_LOCKED
    } state_e;

    state_e              state_q;
    logic [SET_W-1:0]    settle_q;
    logic [DIV_W-1:0]    cnt_q [NUM_CH];
    logic [NUM_CH-1:0]   outclk_q;
    logic [NUM_CH-1:0]   outclk_en_q;
    logic                locked_q;

    // Per-channel settings as seen by the counters.
    logic [DIV_W-1:0]    sh_div   [NUM_CH];
    logic [DIV_W-1:0]    sh_high  [NUM_CH];
    logic [DIV_W-1:0]    sh_phase [NUM_CH];

    // Accepted request that targets an existing channel.
    logic                cfg_hit;

`ifdef PLL_CLKGEN_RECFG_EN
    logic [DIV_W-1:0]    div_q   [NUM_CH];
    logic [DIV_W-1:0]    high_q  [NUM_CH];
    logic [DIV_W-1:0]    phase_q [NUM_CH];
    logic                cfg_fire;
    logic                ch_in_range;

    // Requests are only taken while running and not realigning.
    assign cfg_ready   = enable && (state_q != ST_ALIGN);
    assign cfg_fire    = cfg_valid && cfg_ready;
    // Widened by one bit so the range check is meaningful for every NUM_CH.
    assign ch_in_range = ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));
    assign cfg_hit     = cfg_fire && ch_in_range;

    // Capture a channel's new settings on an accepted in-range request.
    always_ff @(posedge refclk) begin
        // NOTE: the shadow arrays are deliberately reset -- runtime settings
        // must not survive a reset, so this is not a plain storage array.
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i]   <= DIV_W'(DIV_INIT);
                high_q[i]  <= DIV_W'(HIGH_INIT);
                phase_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_hit && (cfg_ch == CH_W'(i))) begin
                    div_q[i]   <= cfg_div;
                    high_q[i]  <= cfg_high;
                    phase_q[i] <= cfg_phase;
                end
            end
        end
    end

    assign sh_div   = div_q;
    assign sh_high  = high_q;
    assign sh_phase = phase_q;
`else
    // Reconfiguration port is inert in this build.
    logic unused_cfg;
    assign unused_cfg = ^{cfg_valid, cfg_ch, cfg_div, cfg_high, cfg_phase};
    assign cfg_ready  = 1'b0;
    assign cfg_hit    = 1'b0;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_fixed_cfg
        assign sh_div[g]   = DIV_W'(DIV_INIT);
        assign sh_high[g]  = DIV_W'(HIGH_INIT);
        assign sh_phase[g] = '0;
    end
`endif

    logic [DIV_W-1:0]  eff_div   [NUM_CH];
    logic [DIV_W-1:0]  align_cnt [NUM_CH];
    logic [DIV_W-1:0]  run_cnt   [NUM_CH];
    logic [NUM_CH-1:0] clk_val;
    logic [NUM_CH-1:0] en_val;

    // Per-channel next-count, realignment load value and output decode.
    always_comb begin
        // NOTE: every signal gets a default before the loop so no path can
        // leave a bit unassigned and infer a latch.
        clk_val = '0;
        en_val  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            // A divide of 0 behaves as 1: counter pinned at 0.
            eff_div[i]   = (sh_div[i] == '0) ? DIV_W'(1) : sh_div[i];
            // Out-of-range phase falls back to phase 0.
            align_cnt[i] = '0;
            if ((sh_phase[i] != '0) && (sh_phase[i] < eff_div[i])) begin
                align_cnt[i] = eff_div[i] - sh_phase[i];
            end
            // >= rather than == so a stray count above the period still wraps.
            run_cnt[i]   = (cnt_q[i] >= (eff_div[i] - DIV_W'(1)))
                         ? '0 : (cnt_q[i] + DIV_W'(1));
            // high >= div yields constant 1 and high == 0 constant 0 for free.
            clk_val[i]   = (cnt_q[i] < sh_high[i]);
            en_val[i]    = (cnt_q[i] == '0);
        end
    end

    // Lock FSM, channel counters and registered outputs.
    always_ff @(posedge refclk) begin
        // NOTE: non-blocking assignments only, so every register here samples
        // the values from before the edge regardless of statement order.
        if (!rst) begin
            state_q     <= ST_ALIGN;
            settle_q    <= '0;
            outclk_q    <= '0;
            outclk_en_q <= '0;
            locked_q    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (!enable) begin
            // Frozen and blanked; counters keep their value until realigned.
            state_q     <= ST_ALIGN;
            outclk_q    <= '0;
            outclk_en_q <= '0;
            locked_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_ALIGN: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        cnt_q[i] <= align_cnt[i];
                    end
                    settle_q    <= '0;
                    outclk_q    <= '0;
                    outclk_en_q <= '0;
                    locked_q    <= 1'b0;
                    state_q     <= ST_SETTLE;
                end
                default: begin
                    // SETTLE and LOCKED both run the counters.
                    for (int i = 0; i < NUM_CH; i++) begin
                        cnt_q[i] <= run_cnt[i];
                    end
                    outclk_q    <= clk_val;
                    outclk_en_q <= en_val;
                    if (cfg_hit) begin
                        // New settings land in the ALIGN cycle that follows.
                        locked_q <= 1'b0;
                        state_q  <= ST_ALIGN;
                    end else if (state_q == ST_SETTLE) begin
                        locked_q <= 1'b0;
                        if (settle_q == SETTLE_LAST) begin
                            state_q <= ST_LOCKED;
                        end else begin
                            settle_q <= settle_q + SET_W'(1);
                        end
                    end else begin
                        locked_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign outclk    = outclk_q;
    assign outclk_en = outclk_en_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_pll_clkgen_multi.sv
// Directed bench for pll_clkgen_multi. Edge numbers j count rising edges
// after the ALIGN edge (j = 0); outputs are sampled 1 time unit after each
// edge. Reconfiguration sequences are compiled only with PLL_CLKGEN_RECFG_EN.
module tb_pll_clkgen_multi;

    localparam int NUM_CH = 5;
    localparam int DIV_W  = 8;

`ifdef PLL_CLKGEN_RECFG_EN
    localparam bit RECFG = 1'b1;
`else
    localparam bit RECFG = 1'b0;
`endif

    logic              refclk = 1'b0;
    logic              rst;
    logic              enable;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [2:0]        cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic [DIV_W-1:0]  cfg_high;
    logic [DIV_W-1:0]  cfg_phase;
    logic [NUM_CH-1:0] outclk;
    logic [NUM_CH-1:0] outclk_en;
    logic              locked;

    int n_tests = 0;
    int n_fail  = 0;

    pll_clkgen_multi #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .LOCK_CYCLES (16),
        .DIV_INIT    (4),
        .HIGH_INIT   (2)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_high  (cfg_high),
        .cfg_phase (cfg_phase),
        .outclk    (outclk),
        .outclk_en (outclk_en),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    // Hand-derived per-channel waveforms for each configuration stage.
    //   default     : div 4, high 2, phase 0 -> count (j-1)%4
    //   stage>=1 ch1: div 5, high 1, phase 2 -> loads 3, count (j+2)%5
    //   stage>=2 ch0: div 0 (as 1), high 1   -> both outputs constant 1
    //   stage>=3 ch2: div 3, high 9, phase 7 -> clk constant 1, count (j-1)%3
    function automatic void expect_vec(input int stage, input int j,
                                       output logic [NUM_CH-1:0] e_clk,
                                       output logic [NUM_CH-1:0] e_en);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            int c;
            if (ch == 0 && stage >= 2) begin
                e_clk[ch] = 1'b1;
                e_en[ch]  = 1'b1;
            end else if (ch == 1 && stage >= 1) begin
                c = (j + 2) % 5;
                e_clk[ch] = (c < 1);
                e_en[ch]  = (c == 0);
            end else if (ch == 2 && stage >= 3) begin
                c = (j - 1) % 3;
                e_clk[ch] = 1'b1;
                e_en[ch]  = (c == 0);
            end else begin
                c = (j - 1) % 4;
                e_clk[ch] = (c < 2);
                e_en[ch]  = (c == 0);
            end
        end
    endfunction

    task automatic run_check(input int stage, input int j_from, input int j_to, input int lock_from);
        logic [NUM_CH-1:0] e_clk;
        logic [NUM_CH-1:0] e_en;
        check($sformatf("cfg_ready s%0d j%0d", stage, j_from - 1), 32'(cfg_ready), 32'(RECFG));
        for (int j = j_from; j <= j_to; j++) begin
            step();
            expect_vec(stage, j, e_clk, e_en);
            check($sformatf("outclk s%0d j%0d", stage, j), 32'(outclk), 32'(e_clk));
            check($sformatf("outclk_en s%0d j%0d", stage, j), 32'(outclk_en), 32'(e_en));
            check($sformatf("locked s%0d j%0d", stage, j), 32'(locked), 32'(j >= lock_from));
        end
    endtask

    task automatic check_blank(input string tag);
        check({tag, " outclk"}, 32'(outclk), 32'(0));
        check({tag, " outclk_en"}, 32'(outclk_en), 32'(0));
        check({tag, " locked"}, 32'(locked), 32'(0));
    endtask

`ifdef PLL_CLKGEN_RECFG_EN
    task automatic handshake(input logic [2:0] ch, input logic [DIV_W-1:0] div,
                             input logic [DIV_W-1:0] high, input logic [DIV_W-1:0] phase);
        cfg_ch    = ch;
        cfg_div   = div;
        cfg_high  = high;
        cfg_phase = phase;
        cfg_valid = 1'b1;
        check($sformatf("hs ready ch%0d", ch), 32'(cfg_ready), 32'(1));
        step();
        cfg_valid = 1'b0;
        check($sformatf("hs locked ch%0d", ch), 32'(locked), 32'(0));
        check($sformatf("hs align ready ch%0d", ch), 32'(cfg_ready), 32'(0));
        step();
        check_blank($sformatf("align ch%0d", ch));
    endtask
`endif

    initial begin
        rst       = 1'b0;
        enable    = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_high  = '0;
        cfg_phase = '0;

        // Reset held for 5 edges with enable high.
        repeat (5) step();
        check_blank("reset");
        check("reset cfg_ready", 32'(cfg_ready), 32'(0));

        // Release: edge 0 is ALIGN, then default 1100 pattern, lock at 17.
        rst = 1'b1;
        step();
        check_blank("first align");
        run_check(0, 1, 20, 17);

`ifdef PLL_CLKGEN_RECFG_EN
        // ch1 -> div 5, high 1, phase 2; all channels realign.
        handshake(3'd1, 8'd5, 8'd1, 8'd2);
        run_check(1, 1, 20, 17);
        // ch0 -> div 0: outclk_en constantly 1.
        handshake(3'd0, 8'd0, 8'd1, 8'd0);
        run_check(2, 1, 6, 1000);
        // ch2 -> high 9 > div 3, phase 7 >= div 3.
        handshake(3'd2, 8'd3, 8'd9, 8'd7);
        run_check(3, 1, 20, 17);
        // Out-of-range channel: consumed, nothing changes, stays locked.
        cfg_ch    = 3'd5;
        cfg_div   = 8'd7;
        cfg_high  = 8'd7;
        cfg_phase = 8'd1;
        cfg_valid = 1'b1;
        run_check(3, 21, 21, 17);
        cfg_valid = 1'b0;
        run_check(3, 22, 28, 17);
`else
        // Port is inert: a held request changes nothing.
        cfg_ch    = 3'd1;
        cfg_div   = 8'd5;
        cfg_high  = 8'd1;
        cfg_phase = 8'd2;
        cfg_valid = 1'b1;
        run_check(0, 21, 30, 17);
        cfg_valid = 1'b0;
`endif

        // Mid-run reset: defaults come back, then enable drop at edge 10.
        rst = 1'b0;
        step();
        step();
        check_blank("reset again");
        rst = 1'b1;
        step();
        check_blank("realign after reset");
        run_check(0, 1, 9, 17);
        enable = 1'b0;
        step();
        check_blank("enable drop");
        check("enable drop cfg_ready", 32'(cfg_ready), 32'(0));
        repeat (3) step();
        check_blank("enable held low");
        enable = 1'b1;
        step();
        check_blank("enable return align");
        run_check(0, 1, 18, 17);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
